bus_req_arbiter: RTL and testbench



---
 rtl/bus_req_arbiter.sv | 125 ++++++++++++
 tb/tb_bus_req_arbiter.sv | 407 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_req_arbiter.sv
// bus_req_arbiter: shares the single Bridge port between two masters (M0 = CPU
// data port, M1 = auxiliary master). One transaction is in flight at a time,
// walking IDLE -> ACCESS -> RESP, with registered bus outputs and a one-cycle
// ack pulse. POLICY selects fixed priority with M1 anti-starvation (0) or
// round-robin (1).
module bus_req_arbiter #(
    parameter int POLICY   = 0,
    parameter int MAX_WAIT = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        m0_req,
    input  logic [31:0] m0_addr,
    input  logic        m0_wen,
    input  logic [31:0] m0_wdata,
    output logic        m0_ack,
    output logic [31:0] m0_rdata,
    input  logic        m1_req,
    input  logic [31:0] m1_addr,
    input  logic        m1_wen,
    input  logic [31:0] m1_wdata,
    output logic        m1_ack,
    output logic [31:0] m1_rdata,
    output logic [31:0] bus_addr,
    output logic        bus_wen,
    output logic [31:0] bus_wdata,
    input  logic [31:0] bus_rdata,
    output logic        grant_id,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    localparam logic [7:0] MAX_WAIT_C = 8'(MAX_WAIT);

    state_t     state;
    logic       last_grant;
    logic [7:0] wait_cnt;
    logic       pick_m1;

    // Winner selection for the current IDLE cycle; a lone requester always wins.
    always_comb begin
        pick_m1 = 1'b0;
        if (m1_req && !m0_req) begin
            pick_m1 = 1'b1;
        end else if (m1_req && m0_req) begin
            if (POLICY == 1) begin
                pick_m1 = ~last_grant;
            end else begin
                pick_m1 = (wait_cnt == MAX_WAIT_C);
            end
        end
    end

    // Transaction FSM with registered bus outputs, acks and arbitration state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            wait_cnt   <= 8'd0;
            grant_id   <= 1'b0;
            busy       <= 1'b0;
            bus_addr   <= 32'd0;
            bus_wen    <= 1'b0;
            bus_wdata  <= 32'd0;
            m0_ack     <= 1'b0;
            m1_ack     <= 1'b0;
            m0_rdata   <= 32'd0;
            m1_rdata   <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    m0_ack  <= 1'b0;
                    m1_ack  <= 1'b0;
                    bus_wen <= 1'b0;
                    if (m0_req || m1_req) begin
                        grant_id   <= pick_m1;
                        last_grant <= pick_m1;
                        bus_addr   <= pick_m1 ? m1_addr  : m0_addr;
                        bus_wen    <= pick_m1 ? m1_wen   : m0_wen;
                        bus_wdata  <= pick_m1 ? m1_wdata : m0_wdata;
                        busy       <= 1'b1;
                        state      <= ACCESS;
                    end
                    // Starvation counter only matters for fixed priority.
                    if (POLICY == 0) begin
                        if (!m1_req || pick_m1) begin
                            wait_cnt <= 8'd0;
                        end else if (m0_req && wait_cnt != MAX_WAIT_C) begin
                            wait_cnt <= wait_cnt + 8'd1;
                        end
                    end
                end
                ACCESS: begin
                    // Read data is captured for writes too; the master ignores it.
                    if (grant_id) begin
                        m1_rdata <= bus_rdata;
                        m1_ack   <= 1'b1;
                    end else begin
                        m0_rdata <= bus_rdata;
                        m0_ack   <= 1'b1;
                    end
                    bus_wen <= 1'b0;
                    state   <= RESP;
                end
                RESP: begin
                    m0_ack <= 1'b0;
                    m1_ack <= 1'b0;
                    busy   <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    state   <= IDLE;
                    bus_wen <= 1'b0;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bus_req_arbiter.sv
// Testbench for bus_req_arbiter: dut_a runs fixed priority (MAX_WAIT=4),
// dut_b runs round-robin; both share master stimulus and each has its own
// word memory standing in for the Bridge.
module tb_bus_req_arbiter;

    typedef struct {
        logic        gid;
        logic [31:0] data;
        logic        chk;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        m0_req, m0_wen, m1_req, m1_wen;
    logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;

    logic        a_m0_ack, a_m1_ack, a_bus_wen, a_grant_id, a_busy;
    logic [31:0] a_m0_rdata, a_m1_rdata, a_bus_addr, a_bus_wdata, a_bus_rdata;
    logic        b_m0_ack, b_m1_ack, b_bus_wen, b_grant_id, b_busy;
    logic [31:0] b_m0_rdata, b_m1_rdata, b_bus_addr, b_bus_wdata, b_bus_rdata;

    logic [31:0] mem_a [256];
    logic [31:0] mem_b [256];
    logic        ld_en = 1'b0;
    logic [7:0]  ld_idx = 8'd0;
    logic [31:0] ld_data = 32'd0;
    int          a_wen_cnt = 0;

    int n_cmp = 0;
    int n_bad = 0;

    exp_t q_a[$];
    exp_t q_b[$];

    always #5 clk = ~clk;

    bus_req_arbiter #(.POLICY(0), .MAX_WAIT(4)) dut_a (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_addr(m0_addr), .m0_wen(m0_wen), .m0_wdata(m0_wdata),
        .m0_ack(a_m0_ack), .m0_rdata(a_m0_rdata),
        .m1_req(m1_req), .m1_addr(m1_addr), .m1_wen(m1_wen), .m1_wdata(m1_wdata),
        .m1_ack(a_m1_ack), .m1_rdata(a_m1_rdata),
        .bus_addr(a_bus_addr), .bus_wen(a_bus_wen), .bus_wdata(a_bus_wdata),
        .bus_rdata(a_bus_rdata), .grant_id(a_grant_id), .busy(a_busy)
    );

    bus_req_arbiter #(.POLICY(1), .MAX_WAIT(8)) dut_b (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_addr(m0_addr), .m0_wen(m0_wen), .m0_wdata(m0_wdata),
        .m0_ack(b_m0_ack), .m0_rdata(b_m0_rdata),
        .m1_req(m1_req), .m1_addr(m1_addr), .m1_wen(m1_wen), .m1_wdata(m1_wdata),
        .m1_ack(b_m1_ack), .m1_rdata(b_m1_rdata),
        .bus_addr(b_bus_addr), .bus_wen(b_bus_wen), .bus_wdata(b_bus_wdata),
        .bus_rdata(b_bus_rdata), .grant_id(b_grant_id), .busy(b_busy)
    );

    // Bridge models: combinational read, write on the edge closing ACCESS.
    assign a_bus_rdata = mem_a[a_bus_addr[9:2]];
    assign b_bus_rdata = mem_b[b_bus_addr[9:2]];

    always @(posedge clk) begin
        if (a_bus_wen) mem_a[a_bus_addr[9:2]] <= a_bus_wdata;
        else if (ld_en) mem_a[ld_idx] <= ld_data;
        if (b_bus_wen) mem_b[b_bus_addr[9:2]] <= b_bus_wdata;
        else if (ld_en) mem_b[ld_idx] <= ld_data;
        if (a_bus_wen) a_wen_cnt <= a_wen_cnt + 1;
    end

    task automatic preload(input logic [7:0] idx, input logic [31:0] data);
        ld_en = 1'b1; ld_idx = idx; ld_data = data;
        @(negedge clk);
        ld_en = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        m0_req = 1'b0; m0_wen = 1'b0; m0_addr = 32'd0; m0_wdata = 32'd0;
        m1_req = 1'b0; m1_wen = 1'b0; m1_addr = 32'd0; m1_wdata = 32'd0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++;
        if ({a_m0_ack, a_m1_ack, a_m0_rdata, a_m1_rdata, a_bus_addr, a_bus_wen,
             a_bus_wdata, a_grant_id, a_busy} !== '0) begin
            n_bad++;
            $display("FAIL reset_a: ack=%b%b addr=%h wen=%b grant=%b busy=%b, required all 0",
                     a_m0_ack, a_m1_ack, a_bus_addr, a_bus_wen, a_grant_id, a_busy);
        end
        n_cmp++;
        if ({b_m0_ack, b_m1_ack, b_m0_rdata, b_m1_rdata, b_bus_addr, b_bus_wen,
             b_bus_wdata, b_grant_id, b_busy} !== '0) begin
            n_bad++;
            $display("FAIL reset_b: ack=%b%b addr=%h wen=%b grant=%b busy=%b, required all 0",
                     b_m0_ack, b_m1_ack, b_bus_addr, b_bus_wen, b_grant_id, b_busy);
        end
    endtask

    task automatic test_m0_read();
        exp_t e;
        int   m1_acks = 0;
        do_reset();
        preload(8'd2, 32'hDEADBEEF);
        e.gid = 1'b0; e.data = 32'hDEADBEEF; e.chk = 1'b1;
        q_a.push_back(e);
        m0_req = 1'b1; m0_addr = 32'h4008; m0_wen = 1'b0;
        for (int cyc = 1; cyc <= 10 && q_a.size() > 0; cyc++) begin
            @(negedge clk);
            if (a_m1_ack) m1_acks++;
            if (cyc == 1) begin
                n_cmp++;
                if ({a_bus_addr, a_bus_wen, a_busy} !== {32'h4008, 1'b0, 1'b1}) begin
                    n_bad++;
                    $display("FAIL m0_read_access: addr=%h wen=%b busy=%b, required 4008/0/1",
                             a_bus_addr, a_bus_wen, a_busy);
                end
            end
            if (a_m0_ack) begin
                e = q_a.pop_front();
                m0_req = 1'b0;
                n_cmp++;
                if (cyc != 2 || a_m0_rdata !== e.data || a_grant_id !== e.gid) begin
                    n_bad++;
                    $display("FAIL m0_read_ack: cycle=%0d rdata=%h gid=%b, required 2/%h/%b",
                             cyc, a_m0_rdata, a_grant_id, e.data, e.gid);
                end
            end
        end
        m0_req = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (a_m1_ack) m1_acks++;
        end
        n_cmp++;
        if (q_a.size() != 0 || m1_acks != 0) begin
            n_bad++;
            $display("FAIL m0_read_done: pending=%0d m1_acks=%0d, required 0/0", q_a.size(), m1_acks);
        end
        n_cmp++;
        if ({a_m0_ack, a_m0_rdata, a_busy} !== {1'b0, 32'hDEADBEEF, 1'b0}) begin
            n_bad++;
            $display("FAIL m0_rdata_hold: ack=%b rdata=%h busy=%b, required 0/deadbeef/0",
                     a_m0_ack, a_m0_rdata, a_busy);
        end
        q_a.delete();
    endtask

    task automatic test_write_read();
        exp_t e;
        int   wcnt0;
        do_reset();
        wcnt0 = a_wen_cnt;
        // Write phase
        e.gid = 1'b1; e.data = 32'd0; e.chk = 1'b0;
        q_a.push_back(e);
        m1_req = 1'b1; m1_addr = 32'h4010; m1_wen = 1'b1; m1_wdata = 32'h12345678;
        for (int cyc = 1; cyc <= 10 && q_a.size() > 0; cyc++) begin
            @(negedge clk);
            if (cyc == 1) begin
                n_cmp++;
                if ({a_bus_wen, a_bus_addr, a_bus_wdata} !== {1'b1, 32'h4010, 32'h12345678}) begin
                    n_bad++;
                    $display("FAIL write_access: wen=%b addr=%h wdata=%h, required 1/4010/12345678",
                             a_bus_wen, a_bus_addr, a_bus_wdata);
                end
            end
            if (a_m1_ack || a_m0_ack) begin
                e = q_a.pop_front();
                m1_req = 1'b0;
                n_cmp++;
                if ({a_m1_ack, a_m0_ack, a_grant_id} !== {1'b1, 1'b0, e.gid}) begin
                    n_bad++;
                    $display("FAIL write_ack: acks=%b%b gid=%b, required m1 ack gid=%b",
                             a_m1_ack, a_m0_ack, a_grant_id, e.gid);
                end
            end
        end
        m1_req = 1'b0;
        @(negedge clk);
        @(negedge clk);
        n_cmp++;
        if (a_wen_cnt - wcnt0 != 1 || mem_a[4] !== 32'h12345678) begin
            n_bad++;
            $display("FAIL write_effect: wen_pulses=%0d mem=%h, required 1/12345678",
                     a_wen_cnt - wcnt0, mem_a[4]);
        end
        // Read-back phase
        e.gid = 1'b1; e.data = 32'h12345678; e.chk = 1'b1;
        q_a.push_back(e);
        m1_req = 1'b1; m1_wen = 1'b0;
        for (int cyc = 1; cyc <= 10 && q_a.size() > 0; cyc++) begin
            @(negedge clk);
            if (a_m1_ack) begin
                e = q_a.pop_front();
                m1_req = 1'b0;
                n_cmp++;
                if (a_m1_rdata !== e.data || a_grant_id !== e.gid) begin
                    n_bad++;
                    $display("FAIL read_back: rdata=%h gid=%b, required %h/%b",
                             a_m1_rdata, a_grant_id, e.data, e.gid);
                end
            end
        end
        m1_req = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (q_a.size() != 0 || a_wen_cnt - wcnt0 != 1) begin
            n_bad++;
            $display("FAIL write_read_done: pending=%0d wen_pulses=%0d, required 0/1",
                     q_a.size(), a_wen_cnt - wcnt0);
        end
        q_a.delete();
    endtask

    task automatic test_round_robin();
        exp_t e;
        int   last = -1;
        do_reset();
        preload(8'd2, 32'hDEADBEEF);
        preload(8'd4, 32'hCAFEF00D);
        for (int i = 0; i < 6; i++) begin
            e.gid = (i % 2 == 1); e.data = (i % 2 == 1) ? 32'hCAFEF00D : 32'hDEADBEEF; e.chk = 1'b1;
            q_b.push_back(e);
        end
        m0_req = 1'b1; m0_addr = 32'h4008; m0_wen = 1'b0;
        m1_req = 1'b1; m1_addr = 32'h4010; m1_wen = 1'b0;
        for (int cyc = 1; cyc <= 40 && q_b.size() > 0; cyc++) begin
            @(negedge clk);
            if (b_m0_ack || b_m1_ack) begin
                e = q_b.pop_front();
                n_cmp++;
                if ({b_m1_ack, b_m0_ack, b_grant_id} !== {e.gid, ~e.gid, e.gid} ||
                    (e.gid ? b_m1_rdata : b_m0_rdata) !== e.data) begin
                    n_bad++;
                    $display("FAIL rr_grant: acks=%b%b gid=%b rdata=%h, required gid=%b rdata=%h",
                             b_m1_ack, b_m0_ack, b_grant_id, e.gid ? b_m1_rdata : b_m0_rdata,
                             e.gid, e.data);
                end
                n_cmp++;
                if ((last < 0 && cyc != 2) || (last >= 0 && cyc - last != 3)) begin
                    n_bad++;
                    $display("FAIL rr_spacing: ack at cycle %0d, previous %0d, required first at 2 then every 3",
                             cyc, last);
                end
                last = cyc;
            end
        end
        m0_req = 1'b0; m1_req = 1'b0;
        n_cmp++;
        if (q_b.size() != 0) begin
            n_bad++;
            $display("FAIL rr_timeout: pending=%0d, required 0", q_b.size());
        end
        q_b.delete();
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic test_fixed_priority();
        exp_t e;
        logic gids [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        do_reset();
        preload(8'd2, 32'hDEADBEEF);
        preload(8'd4, 32'hCAFEF00D);
        for (int i = 0; i < 6; i++) begin
            e.gid = gids[i]; e.data = gids[i] ? 32'hCAFEF00D : 32'hDEADBEEF; e.chk = 1'b1;
            q_a.push_back(e);
        end
        m0_req = 1'b1; m0_addr = 32'h4008; m0_wen = 1'b0;
        m1_req = 1'b1; m1_addr = 32'h4010; m1_wen = 1'b0;
        for (int cyc = 1; cyc <= 40 && q_a.size() > 0; cyc++) begin
            @(negedge clk);
            if (a_m0_ack || a_m1_ack) begin
                e = q_a.pop_front();
                n_cmp++;
                if ({a_m1_ack, a_m0_ack, a_grant_id} !== {e.gid, ~e.gid, e.gid} ||
                    (e.gid ? a_m1_rdata : a_m0_rdata) !== e.data) begin
                    n_bad++;
                    $display("FAIL fp_grant: acks=%b%b gid=%b rdata=%h, required gid=%b rdata=%h",
                             a_m1_ack, a_m0_ack, a_grant_id, e.gid ? a_m1_rdata : a_m0_rdata,
                             e.gid, e.data);
                end
                if (e.gid) begin
                    n_cmp++;
                    if (dut_a.wait_cnt !== 8'd0) begin
                        n_bad++;
                        $display("FAIL fp_wait_clear: wait_cnt=%0d, required 0", dut_a.wait_cnt);
                    end
                end
            end
        end
        m0_req = 1'b0; m1_req = 1'b0;
        n_cmp++;
        if (q_a.size() != 0) begin
            n_bad++;
            $display("FAIL fp_timeout: pending=%0d, required 0", q_a.size());
        end
        q_a.delete();
        @(negedge clk);
        @(negedge clk);
        n_cmp++;
        if (dut_a.wait_cnt !== 8'd0) begin
            n_bad++;
            $display("FAIL fp_wait_idle: wait_cnt=%0d, required 0", dut_a.wait_cnt);
        end
    endtask

    task automatic test_reset_mid_write();
        int wcnt0;
        int acks = 0;
        do_reset();
        preload(8'd6, 32'hA5A5A5A5);
        wcnt0 = a_wen_cnt;
        m0_req = 1'b1; m0_addr = 32'h4018; m0_wen = 1'b1; m0_wdata = 32'h11111111;
        @(negedge clk);
        n_cmp++;
        if (a_bus_wen !== 1'b1) begin
            n_bad++;
            $display("FAIL rstmid_access: wen=%b, required 1", a_bus_wen);
        end
        #2 rst = 1'b0;
        #1;
        n_cmp++;
        if ({a_bus_wen, a_m0_ack, a_m1_ack, a_busy} !== 4'b0000) begin
            n_bad++;
            $display("FAIL rstmid_async: wen=%b acks=%b%b busy=%b, required all 0",
                     a_bus_wen, a_m0_ack, a_m1_ack, a_busy);
        end
        m0_req = 1'b0; m0_wen = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (a_m0_ack || a_m1_ack) acks++;
        end
        n_cmp++;
        if ({a_m0_ack, a_m1_ack, a_m0_rdata, a_m1_rdata, a_bus_addr, a_bus_wen,
             a_bus_wdata, a_grant_id, a_busy} !== '0 || acks != 0) begin
            n_bad++;
            $display("FAIL rstmid_after: addr=%h wdata=%h busy=%b acks_seen=%0d, required all 0",
                     a_bus_addr, a_bus_wdata, a_busy, acks);
        end
        n_cmp++;
        if (mem_a[6] !== 32'hA5A5A5A5 || a_wen_cnt != wcnt0) begin
            n_bad++;
            $display("FAIL rstmid_mem: mem=%h wen_pulses=%0d, required a5a5a5a5/0",
                     mem_a[6], a_wen_cnt - wcnt0);
        end
    endtask

    task automatic test_m1_pulse();
        exp_t e;
        int   m1_acks = 0;
        do_reset();
        preload(8'd2, 32'hDEADBEEF);
        e.gid = 1'b0; e.data = 32'hDEADBEEF; e.chk = 1'b1;
        q_a.push_back(e);
        m0_req = 1'b1; m0_addr = 32'h4008; m0_wen = 1'b0;
        for (int cyc = 1; cyc <= 8; cyc++) begin
            @(negedge clk);
            if (a_m1_ack) m1_acks++;
            if (a_m0_ack && q_a.size() > 0) begin
                e = q_a.pop_front();
                m0_req = 1'b0;
                n_cmp++;
                if (a_m0_rdata !== e.data || a_grant_id !== e.gid) begin
                    n_bad++;
                    $display("FAIL pulse_m0: rdata=%h gid=%b, required %h/%b",
                             a_m0_rdata, a_grant_id, e.data, e.gid);
                end
            end
            m1_req = (cyc == 1);
            m1_addr = 32'h4010; m1_wen = 1'b0;
        end
        m1_req = 1'b0;
        n_cmp++;
        if (m1_acks != 0 || a_grant_id !== 1'b0 || q_a.size() != 0) begin
            n_bad++;
            $display("FAIL pulse_m1: m1_acks=%0d gid=%b pending=%0d, required 0/0/0",
                     m1_acks, a_grant_id, q_a.size());
        end
        q_a.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_m0_read();
        test_write_read();
        test_round_robin();
        test_fixed_priority();
        test_reset_mid_write();
        test_m1_pulse();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
